// File: rtl/seq_chunk_adder_ctrl_pkg.sv
// Shared types and elaboration helpers for the chunked add/subtract unit.
// Optional feature macro: BACK_TO_BACK_EN (see seq_chunk_adder_ctrl.sv).
package seq_chunk_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic bit width_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_ctrl_if.sv
// Operand/result handshake bundle for seq_chunk_adder_ctrl.
// Optional feature macro: BACK_TO_BACK_EN (affects in_ready only).
interface seq_chunk_adder_ctrl_if #(
    parameter int WIDTH = 32
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/seq_chunk_adder_ctrl_rca.sv
// Plain ripple-carry adder, bits wide; the shared datapath of the unit.
// Optional feature macro: BACK_TO_BACK_EN (not used here).
module seq_chunk_adder_ctrl_rca #(
    parameter int bits = 8
) (
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic            ci,
    output logic [bits-1:0] s,
    output logic            co
);

    logic [bits:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < bits; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co = c[bits];

endmodule

// File: rtl/seq_chunk_adder_ctrl.sv
// Multi-cycle WIDTH-bit add/sub reusing one CHUNK-bit adder, LSB chunk first.
// Define BACK_TO_BACK_EN to allow DONE->RUN on a simultaneous handshake.
module seq_chunk_adder_ctrl
    import seq_chunk_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic                  clk,
    input logic                  rst,
    seq_chunk_adder_ctrl_if.slave bus
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    generate
        if (!width_ok(WIDTH, CHUNK)) begin : g_bad_width
            $error("WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_n;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] ar, br, res, res_n, sum_q;
    logic             cout_q, ovf_q;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             ld, last;

    seq_chunk_adder_ctrl_rca #(.bits(CHUNK)) u_rca (
        .a  (ar[CHUNK-1:0]),
        .b  (br[CHUNK-1:0]),
        .ci (carry),
        .s  (s),
        .co (co)
    );

`ifdef BACK_TO_BACK_EN
    assign bus.in_ready = (state == IDLE) ||
                          ((state == DONE) && bus.out_ready);
`else
    assign bus.in_ready = (state == IDLE);
`endif

    assign ld    = bus.in_valid & bus.in_ready;
    assign last  = (idx == LAST);
    assign res_n = (res >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (ld) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE: begin
                if (ld)
                    state_n = RUN;
                else if (bus.out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            ar     <= '0;
            br     <= '0;
            res    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (ld) begin
                ar    <= bus.a;
                br    <= bus.sub ? ~bus.b : bus.b;
                carry <= bus.sub;
                idx   <= '0;
            end else if (state == RUN) begin
                ar    <= ar >> CHUNK;
                br    <= br >> CHUNK;
                res   <= res_n;
                carry <= co;
                idx   <= idx + 1'b1;
                // carry into the MSB is recovered from its sum bit
                if (last) begin
                    sum_q  <= res_n;
                    cout_q <= co;
                    ovf_q  <= s[CHUNK-1] ^ ar[CHUNK-1] ^ br[CHUNK-1] ^ co;
                end
            end
        end
    end

    assign bus.out_valid = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder_ctrl.sv
// Directed scoreboard bench for seq_chunk_adder_ctrl (WIDTH=32, CHUNK=8).
// Define BACK_TO_BACK_EN to expect the back-to-back result spacing.
module tb_seq_chunk_adder_ctrl;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef BACK_TO_BACK_EN
    localparam int SPACING = NCHUNK + 1;
`else
    localparam int SPACING = NCHUNK + 2;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_chunk_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    seq_chunk_adder_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic res_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic s);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   w;
        res_t             r;
        bb     = s ? ~b : b;
        w      = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s);
        r.sum  = w[WIDTH-1:0];
        r.cout = w[WIDTH];
        r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) &&
                 (r.sum[WIDTH-1] != a[WIDTH-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic s);
        @(negedge clk);
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        q.push_back(model(a, b, s));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        @(negedge clk);
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, NCHUNK + 1);
    endtask

    task automatic collect();
        res_t e;
        check("sb_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("sum", bus.sum, e.sum);
            check("cout", bus.cout, e.cout);
            check("ovf", bus.ovf, e.ovf);
        end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("idle_out_valid", bus.out_valid, 0);
        check("idle_in_ready", bus.in_ready, 1);
    endtask

    task automatic do_op(input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic s);
        int n;
        send(a, b, s);
        wait_done(n);
        collect();
        release_out();
    endtask

    initial begin
        int   n;
        int   t[3];
        int   got;
        int   sent;
        int   cyc;
        logic acc;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        rst = 1'b0;

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1);

        // backpressure: DONE must hold and ignore new operands
        send(32'h1111_1111, 32'h2222_2222, 1'b0);
        wait_done(n);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_sum", bus.sum, q[0].sum);
            bus.in_valid = (i == 3);
            bus.a        = 32'hDEAD_BEEF;
            bus.b        = 32'h0BAD_F00D;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        collect();
        release_out();
        repeat (8) @(negedge clk);
        check("bp_no_ghost", bus.out_valid, 0);

        // reset in RUN at idx=2
        send(32'h1234_5678, 32'h0000_0001, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_sum", bus.sum, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        void'(q.pop_front());
        do_op(32'd3, 32'd4, 1'b0);

        // throughput with out_ready high and in_valid continuous
        got  = 0;
        sent = 0;
        cyc  = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 32'h0F0F_0F0F;
        bus.b        = 32'h0000_0007;
        bus.sub      = 1'b0;
        while (got < 3 && cyc < 100) begin
            acc = 1'b0;
            if (bus.out_valid === 1'b1) begin
                t[got] = cyc;
                collect();
                got++;
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                q.push_back(model(bus.a, bus.b, bus.sub));
                sent++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                if (sent < 3) begin
                    bus.a   = 32'(sent) * 32'h0101_0101 + 32'h0F0F_0F0F;
                    bus.b   = 32'h0000_0007;
                    bus.sub = sent[0];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("tput_count", got, 3);
        if (got == 3) begin
            check("tput_gap0", t[1] - t[0], SPACING);
            check("tput_gap1", t[2] - t[1], SPACING);
        end
        check("sb_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
